// File: rtl/retx_req_sched.sv
// MoldUDP64 retransmission request scheduler: queues gap reports from the miss detector and a retry path,
// then splits each gap into request-sized chunks. Optional macro RETX_RATE_LIMIT_EN adds an idle gap after each request.
module retx_req_sched #(
  parameter int unsigned SID_W                   = 80,
  parameter int unsigned SEQ_NUM_W               = 64,
  parameter int unsigned ML_W                    = 16,
  parameter logic [ML_W-1:0] REQ_CNT_MAX         = 16'hFFFF,
  parameter int unsigned FIFO_D                  = 4,
  parameter int unsigned GAP_CYC_W               = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  input  logic                 retry_v_i,
  output logic                 retry_ready_o,
  input  logic [SID_W-1:0]     retry_sid_i,
  input  logic [SEQ_NUM_W-1:0] retry_start_i,
  input  logic [SEQ_NUM_W-1:0] retry_cnt_i,
  output logic                 req_v_o,
  input  logic                 req_ready_i,
  output logic [SID_W-1:0]     req_sid_o,
  output logic [SEQ_NUM_W-1:0] req_seq_o,
  output logic [ML_W-1:0]      req_cnt_o,
  output logic                 busy_o,
  output logic                 ovf_o
`ifdef RETX_RATE_LIMIT_EN
  ,
  input  logic [GAP_CYC_W-1:0] gap_cyc_i
`endif
);

  localparam int unsigned AW    = $clog2(FIFO_D);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned ENT_W = SID_W + 2 * SEQ_NUM_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Gap queue
  logic [ENT_W-1:0] mem_q [FIFO_D];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             full, empty;
  logic             push_miss, push_retry, push, pop;
  logic [ENT_W-1:0] wdata, rdata;

  assign full  = (cnt_q == CW'(FIFO_D));
  assign empty = (cnt_q == '0);

  assign retry_ready_o = ~full & ~miss_v_i;
  // Zero-length reports are handshaken but never occupy a slot.
  assign push_miss  = miss_v_i & ~full & (miss_cnt_i != '0);
  assign push_retry = retry_v_i & retry_ready_o & (retry_cnt_i != '0);
  assign push       = push_miss | push_retry;
  assign wdata      = push_miss ? {miss_sid_i, miss_start_i, miss_cnt_i}
                                : {retry_sid_i, retry_start_i, retry_cnt_i};
  assign rdata      = mem_q[rd_ptr_q];

  // Working registers and FSM
  logic [1:0]           state_q, state_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  logic [SEQ_NUM_W-1:0] seq_q, seq_d;
  logic [SEQ_NUM_W-1:0] rem_q, rem_d;
  logic [ML_W-1:0]      chunk;
  logic [SEQ_NUM_W-1:0] rem_after;
`ifdef RETX_RATE_LIMIT_EN
  logic [GAP_CYC_W-1:0] gap_q, gap_d;
`endif

  assign pop       = (state_q == ST_IDLE) & ~empty;
  assign chunk     = (rem_q > SEQ_NUM_W'(REQ_CNT_MAX)) ? REQ_CNT_MAX : rem_q[ML_W-1:0];
  assign rem_after = rem_q - SEQ_NUM_W'(chunk);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sid_d   = sid_q;
    seq_d   = seq_q;
    rem_d   = rem_q;
`ifdef RETX_RATE_LIMIT_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          sid_d   = rdata[ENT_W-1 -: SID_W];
          seq_d   = rdata[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
          rem_d   = rdata[SEQ_NUM_W-1:0];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (req_ready_i) begin
          seq_d   = seq_q + SEQ_NUM_W'(chunk);
          rem_d   = rem_after;
          state_d = (rem_after == '0) ? ST_IDLE : ST_SEND;
`ifdef RETX_RATE_LIMIT_EN
          if (gap_cyc_i != '0) begin
            gap_d   = gap_cyc_i;
            state_d = ST_WAIT;
          end
`endif
        end
      end
`ifdef RETX_RATE_LIMIT_EN
      ST_WAIT: begin
        if (gap_q <= GAP_CYC_W'(1)) begin
          gap_d   = '0;
          state_d = (rem_q != '0) ? ST_SEND : ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_CYC_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sid_q    <= '0;
      seq_q    <= '0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef RETX_RATE_LIMIT_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sid_q   <= sid_d;
      seq_q   <= seq_d;
      rem_q   <= rem_d;
`ifdef RETX_RATE_LIMIT_EN
      gap_q   <= gap_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (miss_v_i & full) ovf_q <= 1'b1;
    end
  end

  // NOTE: queue storage is not reset; the pointers and count alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign req_v_o   = (state_q == ST_SEND);
  assign req_sid_o = sid_q;
  assign req_seq_o = seq_q;
  assign req_cnt_o = chunk;
  assign busy_o    = (state_q != ST_IDLE) | ~empty;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_retx_req_sched.sv
// Scoreboard bench for retx_req_sched: directed gap reports, expected requests queued, a monitor checks each accept.
module tb_retx_req_sched;

  typedef struct {
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_v_i, retry_v_i, req_ready_i;
  logic [79:0] miss_sid_i, retry_sid_i;
  logic [63:0] miss_start_i, miss_cnt_i, retry_start_i, retry_cnt_i;
  logic        retry_ready_o, req_v_o, busy_o, ovf_o;
  logic [79:0] req_sid_o;
  logic [63:0] req_seq_o;
  logic [15:0] req_cnt_o;
`ifdef RETX_RATE_LIMIT_EN
  logic [15:0] gap_cyc_i;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  retx_req_sched dut (
    .clk          (clk),
    .reset        (reset),
    .miss_v_i     (miss_v_i),
    .miss_sid_i   (miss_sid_i),
    .miss_start_i (miss_start_i),
    .miss_cnt_i   (miss_cnt_i),
    .retry_v_i    (retry_v_i),
    .retry_ready_o(retry_ready_o),
    .retry_sid_i  (retry_sid_i),
    .retry_start_i(retry_start_i),
    .retry_cnt_i  (retry_cnt_i),
    .req_v_o      (req_v_o),
    .req_ready_i  (req_ready_i),
    .req_sid_o    (req_sid_o),
    .req_seq_o    (req_seq_o),
    .req_cnt_o    (req_cnt_o),
    .busy_o       (busy_o),
    .ovf_o        (ovf_o)
`ifdef RETX_RATE_LIMIT_EN
    ,
    .gap_cyc_i    (gap_cyc_i)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    exp_t e;
    e.sid = sid;
    e.seq = seq;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic push_miss(input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
    miss_v_i     = 1'b1;
    miss_sid_i   = sid;
    miss_start_i = start;
    miss_cnt_i   = cnt;
    tick();
    miss_v_i     = 1'b0;
  endtask

  task automatic wait_v(input string name, input int max_cyc);
    int i = 0;
    while (!req_v_o && i < max_cyc) begin
      tick();
      i++;
    end
    check(name, 128'(req_v_o), 128'(1));
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i = 0;
    while (busy_o && i < max_cyc) begin
      tick();
      i++;
    end
    check(name, 128'(busy_o), 128'(0));
  endtask

  // Monitor: every accepted request must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && req_v_o && req_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_req", 128'(req_v_o), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        check("req_sid", 128'(req_sid_o), 128'(mon_e.sid));
        check("req_seq", 128'(req_seq_o), 128'(mon_e.seq));
        check("req_cnt", 128'(req_cnt_o), 128'(mon_e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    miss_v_i = 1'b0; miss_sid_i = '0; miss_start_i = '0; miss_cnt_i = '0;
    retry_v_i = 1'b0; retry_sid_i = '0; retry_start_i = '0; retry_cnt_i = '0;
    req_ready_i = 1'b0;
`ifdef RETX_RATE_LIMIT_EN
    gap_cyc_i = '0;
`endif
    repeat (3) tick();
    check("rst_req_v", 128'(req_v_o), 128'(0));
    check("rst_ovf", 128'(ovf_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_data", {req_sid_o, req_cnt_o}, 128'(0));
    check("rst_seq", 128'(req_seq_o), 128'(0));
    check("rst_retry_ready", 128'(retry_ready_o), 128'(1));
    reset = 1'b0;
    tick();

    // Single report: request appears one cycle after the pop
    req_ready_i = 1'b1;
    expect_req(80'd5, 64'd100, 16'd3);
    push_miss(80'd5, 64'd100, 64'd3);
    check("single_not_early", 128'(req_v_o), 128'(0));
    check("single_busy", 128'(busy_o), 128'(1));
    tick();
    check("single_latency", 128'(req_v_o), 128'(1));
    wait_idle("single_idle", 20);

    // Split across REQ_CNT_MAX, second chunk without bubble
    expect_req(80'd7, 64'd10, 16'd65535);
    expect_req(80'd7, 64'd65545, 16'd4465);
    push_miss(80'd7, 64'd10, 64'd70000);
    wait_v("split_v", 10);
    check("split_first_cnt", 128'(req_cnt_o), 128'(65535));
    tick();
    check("split_no_bubble", 128'(req_v_o), 128'(1));
    check("split_second_seq", 128'(req_seq_o), 128'(65545));
    tick();
    check("split_done", 128'(req_v_o), 128'(0));
    wait_idle("split_idle", 20);

    // Backpressure: outputs held for 5 cycles, accepted on the 6th
    req_ready_i = 1'b0;
    expect_req(80'd9, 64'd200, 16'd5);
    push_miss(80'd9, 64'd200, 64'd5);
    wait_v("bp_v", 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_v", 128'(req_v_o), 128'(1));
      check("bp_hold_data", {req_sid_o[31:0], req_seq_o, req_cnt_o}, {32'd9, 64'd200, 16'd5});
      tick();
    end
    req_ready_i = 1'b1;
    tick();
    check("bp_accepted", 128'(req_v_o), 128'(0));
    wait_idle("bp_idle", 20);

    // Same-cycle detector and retry reports: detector wins, retry next cycle
    expect_req(80'd1, 64'd1000, 16'd2);
    expect_req(80'd2, 64'd2000, 16'd1);
    miss_v_i = 1'b1; miss_sid_i = 80'd1; miss_start_i = 64'd1000; miss_cnt_i = 64'd2;
    retry_v_i = 1'b1; retry_sid_i = 80'd2; retry_start_i = 64'd2000; retry_cnt_i = 64'd1;
    #1;
    check("retry_blocked", 128'(retry_ready_o), 128'(0));
    tick();
    miss_v_i = 1'b0;
    #1;
    check("retry_ready_next", 128'(retry_ready_o), 128'(1));
    tick();
    retry_v_i = 1'b0;
    wait_idle("order_idle", 30);

    // Overflow: fill the queue behind a stalled request, drop one more detector report
    req_ready_i = 1'b0;
    expect_req(80'h10, 64'd0, 16'd1);
    expect_req(80'h12, 64'd50, 16'd2);
    expect_req(80'h13, 64'hFFFF_FFFF_FFFF_FFFE, 16'd3);
    expect_req(80'h14, 64'd7, 16'd65535);
    expect_req(80'h15, 64'hFFFF_FFFF_FFFF_FFF0, 16'd65535);
    expect_req(80'h15, 64'h0000_0000_0000_FFEF, 16'd6);
    push_miss(80'h10, 64'd0, 64'd1);
    push_miss(80'h11, 64'd99, 64'd0);
    push_miss(80'h12, 64'd50, 64'd2);
    push_miss(80'h13, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    push_miss(80'h14, 64'd7, 64'd65535);
    push_miss(80'h15, 64'hFFFF_FFFF_FFFF_FFF0, 64'd65541);
    check("fifo_full", 128'(retry_ready_o), 128'(0));
    check("ovf_before", 128'(ovf_o), 128'(0));
    push_miss(80'h16, 64'd500, 64'd4);
    check("ovf_set", 128'(ovf_o), 128'(1));
    req_ready_i = 1'b1;
    wait_idle("ovf_drain", 100);
    check("ovf_sticky", 128'(ovf_o), 128'(1));

    // Reset mid-operation drops queued and in-flight work
    req_ready_i = 1'b0;
    push_miss(80'h20, 64'd5, 64'd9);
    push_miss(80'h21, 64'd6, 64'd9);
    wait_v("rst_mid_v", 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_req_v", 128'(req_v_o), 128'(0));
    check("rst_mid_busy", 128'(busy_o), 128'(0));
    check("rst_mid_ovf", 128'(ovf_o), 128'(0));
    req_ready_i = 1'b1;
    repeat (4) tick();
    check("rst_mid_quiet", 128'(req_v_o), 128'(0));

`ifdef RETX_RATE_LIMIT_EN
    // Rate limit: 3 idle cycles between chunk accepts
    begin
      int z = 0;
      gap_cyc_i = 16'd3;
      expect_req(80'h30, 64'd10, 16'd65535);
      expect_req(80'h30, 64'd65545, 16'd4465);
      push_miss(80'h30, 64'd10, 64'd70000);
      wait_v("gap_v", 10);
      tick();
      while (!req_v_o && z < 10) begin
        z++;
        tick();
      end
      check("gap_cycles", 128'(z), 128'(3));
      wait_idle("gap_idle", 30);
      gap_cyc_i = '0;
    end
`endif

    repeat (2) tick();
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
